// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: transmit FSM states and default baud divisor.
package uart_tx_pkg;

  // 100 MHz / 115200 baud
  localparam int unsigned DefaultClksPerBit = 868;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_if.sv
// CPU-side write port and serial line of the UART transmitter.
interface uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;

  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  busy;
  logic [CountWidth-1:0] count;
  logic                  tx;

  modport master (output wr_en, wr_data, input full, busy, count, tx);
  modport slave  (input wr_en, wr_data, output full, busy, count, tx);
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers; shared by the UART transmit and receive paths.
module uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned Aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[Aw-1:0]] <= wdata;
  end

  // Same index but different lap bit means the writer is a whole buffer ahead.
  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {Aw{1'b0}}};
  assign empty = wr_ptr_q == rd_ptr_q;
  assign count = wr_ptr_q - rd_ptr_q;
  assign rdata = mem[rd_ptr_q[Aw-1:0]];

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; tx is driven straight from a flop.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DefaultClksPerBit,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       cpuclk,
  input  logic       rst,
  uart_tx_if.slave   bus
);
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TimerWidth = $clog2(CLKS_PER_BIT);
  localparam logic [TimerWidth-1:0] TimerReload = TimerWidth'(CLKS_PER_BIT - 1);

  uart_tx_state_t        state_q, state_d;
  logic [TimerWidth-1:0] timer_q, timer_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;

  logic                  pop;
  logic [7:0]            head;
  logic                  fifo_full, fifo_empty;
  logic [CountWidth-1:0] fifo_count;

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (cpuclk),
    .rst   (rst),
    .push  (bus.wr_en),
    .wdata (bus.wr_data),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head;
          timer_d = TimerReload;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == '0) begin
          timer_d   = TimerReload;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = StData;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StData: begin
        if (timer_q == '0) begin
          timer_d = TimerReload;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            // Next bit is presented from the pre-shift value to avoid a cycle of lag.
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StStop: begin
        if (timer_q == '0) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge cpuclk) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.full  = fifo_full;
  assign bus.count = fifo_count;
  assign bus.busy  = ~fifo_empty | (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Directed and random checks of uart_tx against a frame-timing model and a mid-bit receiver.
module tb_uart_tx;
  localparam int unsigned Cpb   = 4;
  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if #(.FIFO_DEPTH(Depth)) bus_if ();

  uart_tx #(
    .CLKS_PER_BIT (Cpb),
    .FIFO_DEPTH   (Depth)
  ) dut (
    .cpuclk (clk),
    .rst    (rst),
    .bus    (bus_if.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame occupies 10*Cpb cycles from the pop edge; pops happen only when the line is free.
  logic [7:0] mq[$];
  logic [7:0] exp_rx[$];
  logic [7:0] m_byte = 8'h00;
  bit         m_line = 1'b0;
  int         m_t = 0;
  bit         model_valid = 1'b0;
  bit         rst_hit = 1'b0;

  always @(posedge clk) begin
    bit full_pre;
    rst_hit = rst;
    if (rst) begin
      mq.delete();
      exp_rx.delete();
      m_line = 1'b0;
      m_t = 0;
      model_valid = 1'b1;
    end else begin
      full_pre = (mq.size() == Depth);
      if (m_line) begin
        m_t++;
        if (m_t == 10 * Cpb) m_line = 1'b0;
      end else if (mq.size() > 0) begin
        m_byte = mq.pop_front();
        exp_rx.push_back(m_byte);
        m_line = 1'b1;
        m_t = 0;
      end
      if (bus_if.wr_en && !full_pre) mq.push_back(bus_if.wr_data);
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_line) return 1'b1;
    k = m_t / Cpb;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  // Receiver state: samples each bit at its middle, counted from the first low sample.
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_last = 8'h00;

  always @(negedge clk) begin
    if (model_valid) begin
      chk("tx", 32'(bus_if.tx), 32'(exp_tx()));
      chk("busy", 32'(bus_if.busy), 32'(m_line || mq.size() > 0));
      chk("full", 32'(bus_if.full), 32'(mq.size() == Depth));
      chk("count", 32'(bus_if.count), 32'(mq.size()));
      if (rst_hit) begin
        rx_active = 1'b0;
      end else if (!rx_active) begin
        if (bus_if.tx === 1'b0) begin
          rx_active = 1'b1;
          rx_cnt = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % Cpb == Cpb / 2) begin
          if (rx_cnt / Cpb == 9) begin
            chk("rx_stop", 32'(bus_if.tx), 32'd1);
            rx_last = rx_sh;
            if (exp_rx.size() == 0) chk("rx_unexpected", 32'(rx_sh), 32'hxxxx_xxxx);
            else chk("rx_byte", 32'(rx_sh), 32'(exp_rx.pop_front()));
            rx_active = 1'b0;
          end else begin
            rx_sh = {bus_if.tx, rx_sh[7:1]};
          end
        end
      end
    end
  end

  task automatic step(input logic we, input logic [7:0] d);
    bus_if.wr_en   = we;
    bus_if.wr_data = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  initial begin
    logic [9:0] pat;
    rst = 1'b1;
    bus_if.wr_en = 1'b0;
    bus_if.wr_data = 8'h00;
    @(negedge clk);
    idle(2);
    chk("rst_tx", 32'(bus_if.tx), 32'd1);
    chk("rst_count", 32'(bus_if.count), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_full", 32'(bus_if.full), 32'd0);
    rst = 1'b0;
    idle(2);

    // Single 0x55 frame
    step(1'b1, 8'h55);
    chk("w55_count", 32'(bus_if.count), 32'd1);
    chk("w55_tx_hi", 32'(bus_if.tx), 32'd1);
    idle(1);
    chk("w55_start", 32'(bus_if.tx), 32'd0);
    pat = 10'b1010101010;
    for (int b = 0; b < 10; b++) begin
      chk("w55_bit", 32'(bus_if.tx), 32'(pat[b]));
      idle(Cpb);
    end
    chk("w55_busy_lo", 32'(bus_if.busy), 32'd0);
    chk("w55_rx", 32'(rx_last), 32'h55);
    idle(3);

    // Back-to-back frames with a single idle cycle
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    idle(40);
    chk("gap_idle", 32'(bus_if.tx), 32'd1);
    idle(1);
    chk("second_start", 32'(bus_if.tx), 32'd0);
    idle(45);
    chk("b2b_rx", 32'(rx_last), 32'h3C);

    // Overflow: 0x06 dropped
    for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
    chk("ovf_count", 32'(bus_if.count), 32'd4);
    chk("ovf_full", 32'(bus_if.full), 32'd1);
    idle(230);
    chk("ovf_rx_last", 32'(rx_last), 32'h05);

    // Write while full in the pop cycle
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i));
    idle(37);
    step(1'b1, 8'h77);
    chk("popw_count", 32'(bus_if.count), 32'd3);
    chk("popw_full", 32'(bus_if.full), 32'd0);
    idle(200);
    chk("popw_rx_last", 32'(rx_last), 32'h14);

    // Reset in DATA bit 3 of 0xFF with two bytes queued; wr_en held during reset
    step(1'b1, 8'hFF);
    step(1'b1, 8'h0A);
    step(1'b1, 8'h0B);
    idle(15);
    rst = 1'b1;
    step(1'b1, 8'hEE);
    rst = 1'b0;
    chk("mrst_tx", 32'(bus_if.tx), 32'd1);
    chk("mrst_count", 32'(bus_if.count), 32'd0);
    chk("mrst_busy", 32'(bus_if.busy), 32'd0);
    step(1'b1, 8'h81);
    idle(50);
    chk("mrst_rx", 32'(rx_last), 32'h81);

    // Random bytes with random gaps
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'($urandom));
      idle($urandom_range(0, 60));
    end
    idle(300);
    chk("rx_drain", 32'(exp_rx.size()), 32'd0);
    chk("rx_idle", 32'(rx_active), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
